// File: rtl/flex_counter_multi.sv
// Bank of NUM_CH independent wrap-around counters with per-channel direction,
// load and clear, plus an optional cascade where each stage advances on the previous stage's wrap.
module flex_counter_multi #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2,
  parameter bit CASCADE      = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_down,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse
);
  localparam int W = NUM_CNT_BITS;
  typedef logic [W-1:0] cnt_t;

  cnt_t [NUM_CH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] flag_q, flag_d, pulse_q, pulse_d;

  always_comb begin
    logic carry, en, wrap_i;
    cnt_t r, t, c, lv, stepped;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    carry   = 1'b0;
    en      = 1'b0;
    wrap_i  = 1'b0;
    r       = '0;
    t       = '0;
    c       = '0;
    lv      = '0;
    stepped = '0;
    cnt_d   = cnt_q;
    flag_d  = '0;
    pulse_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      r  = rollover_val[i*W +: W];
      lv = load_val[i*W +: W];
      c  = cnt_q[i];
      t  = count_down[i] ? cnt_t'(1) : r;
      // carry holds the previous stage's wrap, so a whole chain can step in one cycle.
      en = count_enable[i] & ((i == 0) | !CASCADE | carry);

      if (r == '0)
        stepped = '0;
      else if (count_down[i])
        stepped = (c <= cnt_t'(1) || c > r) ? r : c - cnt_t'(1);
      else
        stepped = (c >= r) ? cnt_t'(1) : c + cnt_t'(1);

      wrap_i = en & (r != '0) & (c == t) & !clear[i] & !load[i];

      if (clear[i]) begin
        cnt_d[i]  = '0;
        flag_d[i] = 1'b0;
      end else if (load[i]) begin
        cnt_d[i]  = lv;
        flag_d[i] = (lv == t) && (r != '0);
      end else if (en) begin
        cnt_d[i]  = stepped;
        flag_d[i] = (stepped == t) && (r != '0);
      end else begin
        cnt_d[i]  = c;
        flag_d[i] = (c == t) && (r != '0);
      end
      pulse_d[i] = wrap_i;
      carry      = wrap_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all channels update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      flag_q  <= '0;
      pulse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_out      = cnt_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
endmodule

// File: tb/tb_flex_counter_multi.sv
// Drives a free-running and a cascaded counter bank with shared stimulus and
// compares both against an integer reference model every cycle.
module tb_flex_counter_multi;
  localparam int W  = 4;
  localparam int NC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NC-1:0]     clear, count_enable, count_down, load;
  logic [NC*W-1:0]   load_val, rollover_val;
  logic [NC*W-1:0]   count_a, count_c;
  logic [NC-1:0]     flag_a, flag_c, pulse_a, pulse_c;

  flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CH(NC), .CASCADE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .load(load), .load_val(load_val),
    .rollover_val(rollover_val), .count_out(count_a),
    .rollover_flag(flag_a), .rollover_pulse(pulse_a)
  );

  flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CH(NC), .CASCADE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .load(load), .load_val(load_val),
    .rollover_val(rollover_val), .count_out(count_c),
    .rollover_flag(flag_c), .rollover_pulse(pulse_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: index 0 = independent bank, 1 = cascaded bank.
  int m_cnt   [2][NC];
  bit m_flag  [2][NC];
  bit m_pulse [2][NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int step_val(input int c, input int r, input bit dn);
    if (r == 0) return 0;
    if (!dn) return (c >= r) ? 1 : c + 1;
    return (c <= 1 || c > r) ? r : c - 1;
  endfunction

  function automatic logic [31:0] pack_cnt(input int k);
    logic [NC*W-1:0] v;
    logic [31:0] tmp;
    v = '0;
    for (int i = 0; i < NC; i++) begin
      tmp = m_cnt[k][i];
      v[i*W +: W] = tmp[W-1:0];
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] pack_bits(input int k, input bit is_pulse);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i] = is_pulse ? m_pulse[k][i] : m_flag[k][i];
    return v;
  endfunction

  // One clock edge: predict from current inputs, advance, then compare both banks.
  task automatic cycle(input string tag);
    int nc [2][NC];
    bit nf [2][NC];
    bit np [2][NC];
    for (int k = 0; k < 2; k++) begin
      bit carry;
      carry = 1'b0;
      for (int i = 0; i < NC; i++) begin
        int r, t, c, lv, nv;
        bit en, wr;
        r  = int'(rollover_val[i*W +: W]);
        lv = int'(load_val[i*W +: W]);
        c  = m_cnt[k][i];
        t  = count_down[i] ? 1 : r;
        en = count_enable[i] && (i == 0 || k == 0 || carry);
        wr = en && !clear[i] && !load[i] && r != 0 && c == t;
        if (rst)           nv = 0;
        else if (clear[i]) nv = 0;
        else if (load[i])  nv = lv;
        else if (en)       nv = step_val(c, r, count_down[i]);
        else               nv = c;
        nc[k][i] = nv;
        nf[k][i] = !rst && r != 0 && nv == t;
        np[k][i] = !rst && wr;
        carry    = wr;
      end
    end
    @(posedge clk);
    #1;
    m_cnt   = nc;
    m_flag  = nf;
    m_pulse = np;
    check({tag, "/cnt_a"},   32'(count_a), pack_cnt(0));
    check({tag, "/flag_a"},  32'(flag_a),  pack_bits(0, 1'b0));
    check({tag, "/pulse_a"}, 32'(pulse_a), pack_bits(0, 1'b1));
    check({tag, "/cnt_c"},   32'(count_c), pack_cnt(1));
    check({tag, "/flag_c"},  32'(flag_c),  pack_bits(1, 1'b0));
    check({tag, "/pulse_c"}, 32'(pulse_c), pack_bits(1, 1'b1));
  endtask

  task automatic idle_inputs();
    clear = '0; count_enable = '0; count_down = '0; load = '0;
    load_val = '0; rollover_val = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle("reset");
    rst = 1'b0;
  endtask

  initial begin
    int exp1 [12];
    int exp2 [6];
    int pulses;
    exp1 = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    exp2 = '{4, 3, 2, 1, 4, 3};
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NC; i++) begin
        m_cnt[k][i] = 0; m_flag[k][i] = 1'b0; m_pulse[k][i] = 1'b0;
      end

    do_reset();
    check("reset_cnt", 32'(count_a), 32'd0);
    check("reset_flags", 32'({flag_a, pulse_a, flag_c, pulse_c}), 32'd0);

    // Up count, R=5
    rollover_val[0 +: W] = 4'd5;
    count_enable[0] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cycle("up5");
      check("up5_seq",   32'(count_a[W-1:0]), 32'(exp1[n]));
      check("up5_flag",  32'(flag_a[0]),  32'(exp1[n] == 5));
      check("up5_pulse", 32'(pulse_a[0]), 32'(exp1[n] == 1 && n > 0));
    end

    // Down count, R=4
    idle_inputs();
    do_reset();
    rollover_val[0 +: W] = 4'd4;
    count_down[0] = 1'b1;
    count_enable[0] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle("dn4");
      check("dn4_seq",   32'(count_a[W-1:0]), 32'(exp2[n]));
      check("dn4_flag",  32'(flag_a[0]),  32'(exp2[n] == 1));
      check("dn4_pulse", 32'(pulse_a[0]), 32'(n == 4));
    end

    // Cascade: R0=3, R1=2, R2=2
    idle_inputs();
    do_reset();
    rollover_val = {4'd2, 4'd2, 4'd3};
    count_enable = '1;
    pulses = 0;
    for (int n = 0; n < 18; n++) begin
      cycle("casc");
      if (pulse_c[1]) pulses++;
    end
    check("casc_ch1_pulses", 32'(pulses), 32'd2);

    // Clear beats load, then load alone
    idle_inputs();
    do_reset();
    rollover_val[0 +: W] = 4'd7;
    load_val[0 +: W] = 4'd7;
    count_enable[0] = 1'b1;
    load[0] = 1'b1;
    clear[0] = 1'b1;
    cycle("clr_ld");
    check("clr_wins", 32'(count_a[W-1:0]), 32'd0);
    clear[0] = 1'b0;
    cycle("ld7");
    check("ld7_cnt",  32'(count_a[W-1:0]), 32'd7);
    check("ld7_flag", 32'(flag_a[0]), 32'd1);

    // Shrink R below the count, then reset mid-run
    load_val[0 +: W] = 4'd9;
    rollover_val[0 +: W] = 4'd10;
    cycle("ld9");
    load[0] = 1'b0;
    rollover_val[0 +: W] = 4'd6;
    cycle("shrink");
    check("shrink_cnt",  32'(count_a[W-1:0]), 32'd1);
    check("shrink_fp",   32'({flag_a[0], pulse_a[0]}), 32'd0);
    count_enable = '1;
    cycle("run");
    cycle("run");
    rst = 1'b1;
    cycle("midrst");
    check("midrst_all", 32'({count_a, count_c, flag_a, flag_c, pulse_a, pulse_c}), 32'd0);
    rst = 1'b0;

    // Full-range R and R=0
    idle_inputs();
    rollover_val[0 +: W] = 4'd15;
    load_val[0 +: W] = 4'd14;
    load[0] = 1'b1;
    cycle("ld14");
    load[0] = 1'b0;
    count_enable[0] = 1'b1;
    cycle("r15a");
    check("r15_top",  32'({count_a[W-1:0], flag_a[0]}), 32'({4'd15, 1'b1}));
    cycle("r15b");
    check("r15_wrap", 32'({count_a[W-1:0], pulse_a[0]}), 32'({4'd1, 1'b1}));
    rollover_val[0 +: W] = 4'd0;
    for (int n = 0; n < 5; n++) begin
      cycle("r0");
      check("r0_out", 32'({count_a[W-1:0], flag_a[0], pulse_a[0]}), 32'd0);
    end

    // Randomized traffic, small R values favoured so wraps and cascades are frequent
    idle_inputs();
    do_reset();
    for (int i = 0; i < NC; i++) rollover_val[i*W +: W] = 4'($urandom_range(1, 5));
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NC; i++) begin
        clear[i]        = ($urandom_range(0, 24) == 0);
        load[i]         = ($urandom_range(0, 11) == 0);
        count_enable[i] = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 15) == 0) count_down[i] = ~count_down[i];
        if ($urandom_range(0, 19) == 0)
          rollover_val[i*W +: W] = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 5))
                                                                : 4'($urandom_range(0, 15));
        load_val[i*W +: W] = 4'($urandom_range(0, 15));
      end
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
